// File: rtl/ras_ctrl.sv
// Return-address-stack controller: arbitrates predictor (A) and decode-correction (B)
// stack operations and tracks speculative windows, emitting commit/squash strobes.
module ras_ctrl #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 31,
  parameter int OCCW   = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_push,
  input  logic              a_pop,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_push,
  input  logic              b_pop,
  input  logic [WIDTH-1:0]  b_data,
  input  logic              open_valid,
  output logic              open_ready,
  input  logic              res_valid,
  input  logic              res_ok,
  output logic              ras_push,
  output logic              ras_pop,
  output logic [WIDTH-1:0]  ras_din,
  output logic [STAGES-1:0] ras_commit,
  output logic [STAGES-1:0] ras_flush,
  output logic [OCCW-1:0]   occ,
  output logic              err
);

  localparam logic [OCCW-1:0] OCC_MAX = OCCW'(STAGES);

  logic              occ_nz;
  logic              squash;
  logic              res_good;
  logic              err_evt;
  logic              open_acc;
  logic              vld_p0;
  logic              push_p0;
  logic              pop_p0;
  logic [WIDTH-1:0]  din_p0;
  logic [OCCW-1:0]   occ_nxt;
  logic [STAGES-1:0] commit_nxt;
  logic [STAGES-1:0] flush_mask;

  logic              push_p1;
  logic              pop_p1;
  logic [WIDTH-1:0]  din_p1;
  logic [STAGES-1:0] commit_p1;
  logic [STAGES-1:0] flush_p1;
  logic [OCCW-1:0]   occ_p1;
  logic              err_p1;

  // Stage p0: arbitration, window bookkeeping and squash detection
  always_comb begin
    occ_nz     = (occ_p1 != '0);
    squash     = res_valid & ~res_ok & occ_nz;
    res_good   = res_valid & res_ok & occ_nz;
    err_evt    = res_valid & ~occ_nz;
    b_ready    = ~rst_i & ~squash;
    a_ready    = ~rst_i & ~squash & ~b_valid;
    open_ready = ~rst_i & ~squash & ((occ_p1 < OCC_MAX) | (res_valid & res_ok));
    open_acc   = open_valid & open_ready;

    vld_p0  = (b_valid & b_ready) | (a_valid & a_ready);
    push_p0 = b_valid ? b_push : a_push;
    pop_p0  = b_valid ? b_pop  : a_pop;
    din_p0  = b_valid ? b_data : a_data;

    occ_nxt = occ_p1 + {{(OCCW-1){1'b0}}, open_acc} - {{(OCCW-1){1'b0}}, res_good};

    commit_nxt             = '0;
    commit_nxt[0]          = open_acc;
    commit_nxt[STAGES-1]   = commit_nxt[STAGES-1] | res_good;

    flush_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      flush_mask[i] = (i < int'(occ_p1));
    end
  end

  // Stage p1: registered strobes toward the stack
  always_ff @(posedge clk) begin
    if (rst_i) begin
      push_p1   <= 1'b0;
      pop_p1    <= 1'b0;
      din_p1    <= '0;
      commit_p1 <= '0;
      flush_p1  <= '0;
      occ_p1    <= '0;
      err_p1    <= 1'b0;
    end else begin
      push_p1   <= vld_p0 & push_p0;
      pop_p1    <= vld_p0 & pop_p0;
      if (vld_p0) begin
        din_p1 <= din_p0;
      end
      commit_p1 <= squash ? '0 : commit_nxt;
      flush_p1  <= squash ? flush_mask : '0;
      occ_p1    <= squash ? '0 : occ_nxt;
      err_p1    <= err_p1 | err_evt;
    end
  end

  assign ras_push   = push_p1;
  assign ras_pop    = pop_p1;
  assign ras_din    = din_p1;
  assign ras_commit = commit_p1;
  assign ras_flush  = flush_p1;
  assign occ        = occ_p1;
  assign err        = err_p1;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios plus randomized traffic against a
// window-queue reference model.
module tb_ras_ctrl;

  localparam int STAGES = 2;
  localparam int WIDTH  = 31;
  localparam int OCCW   = $clog2(STAGES + 1);
  localparam int OW     = WIDTH + 2 * STAGES + OCCW + 3;

  logic              clk;
  logic              rst_i;
  logic              a_valid, a_ready, a_push, a_pop;
  logic [WIDTH-1:0]  a_data;
  logic              b_valid, b_ready, b_push, b_pop;
  logic [WIDTH-1:0]  b_data;
  logic              open_valid, open_ready;
  logic              res_valid, res_ok;
  logic              ras_push, ras_pop;
  logic [WIDTH-1:0]  ras_din;
  logic [STAGES-1:0] ras_commit, ras_flush;
  logic [OCCW-1:0]   occ;
  logic              err;

  logic [OW-1:0] obs;
  logic [2:0]    rdy;
  assign obs = {ras_push, ras_pop, ras_din, ras_commit, ras_flush, occ, err};
  assign rdy = {a_ready, b_ready, open_ready};

  int n_checks = 0;
  int n_pass   = 0;

  ras_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .OCCW(OCCW)) dut (
    .clk(clk), .rst_i(rst_i),
    .a_valid(a_valid), .a_ready(a_ready), .a_push(a_push), .a_pop(a_pop), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_push(b_push), .b_pop(b_pop), .b_data(b_data),
    .open_valid(open_valid), .open_ready(open_ready),
    .res_valid(res_valid), .res_ok(res_ok),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din),
    .ras_commit(ras_commit), .ras_flush(ras_flush), .occ(occ), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pack(input logic p, input logic q, input logic [WIDTH-1:0] d,
                                         input logic [STAGES-1:0] c, input logic [STAGES-1:0] f,
                                         input int o, input logic e);
    logic [OCCW-1:0] ov;
    ov = OCCW'(o);
    return {p, q, d, c, f, ov, e};
  endfunction

  task automatic idle();
    a_valid = 0; a_push = 0; a_pop = 0; a_data = '0;
    b_valid = 0; b_push = 0; b_pop = 0; b_data = '0;
    open_valid = 0; res_valid = 0; res_ok = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1; a_valid = 1; b_valid = 1; open_valid = 1; res_valid = 1; res_ok = 0;
    #1;
    n_checks++;
    if (rdy !== 3'b000) $display("FAIL reset_ready: got %b want 000", rdy); else n_pass++;
    tick(); tick();
    n_checks++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs); else n_pass++;
    rst_i = 0; idle();
  endtask

  task automatic test_push_a();
    a_valid = 1; a_push = 1; a_data = 31'h1234;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL push_a_ready: got %b want 1", a_ready); else n_pass++;
    tick(); idle();
    n_checks++;
    if (obs !== pack(1, 0, 31'h1234, '0, '0, 0, 0))
      $display("FAIL push_a_out: got %h want %h", obs, pack(1, 0, 31'h1234, '0, '0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_priority();
    a_valid = 1; a_pop = 1; a_data = 31'h77;
    b_valid = 1; b_push = 1; b_data = 31'h55;
    #1;
    n_checks++;
    if ({a_ready, b_ready} !== 2'b01) $display("FAIL prio_ready: got %b want 01", {a_ready, b_ready}); else n_pass++;
    tick();
    b_valid = 0; b_push = 0; b_data = '0;
    n_checks++;
    if (obs !== pack(1, 0, 31'h55, '0, '0, 0, 0))
      $display("FAIL prio_b_out: got %h want %h", obs, pack(1, 0, 31'h55, '0, '0, 0, 0));
    else n_pass++;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL prio_a_held_ready: got %b want 1", a_ready); else n_pass++;
    tick(); idle();
    n_checks++;
    if (obs !== pack(0, 1, 31'h77, '0, '0, 0, 0))
      $display("FAIL prio_a_out: got %h want %h", obs, pack(0, 1, 31'h77, '0, '0, 0, 0));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, '0, '0, 0, 0))
      $display("FAIL idle_hold: got %h want %h", obs, pack(0, 0, 31'h77, '0, '0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_open_full();
    open_valid = 1;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, 2'b01, '0, 1, 0))
      $display("FAIL open1: got %h want %h", obs, pack(0, 0, 31'h77, 2'b01, '0, 1, 0));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, 2'b01, '0, 2, 0))
      $display("FAIL open2: got %h want %h", obs, pack(0, 0, 31'h77, 2'b01, '0, 2, 0));
    else n_pass++;
    n_checks++;
    if (open_ready !== 1'b0) $display("FAIL full_open_ready: got %b want 0", open_ready); else n_pass++;
    res_valid = 1; res_ok = 1;
    #1;
    n_checks++;
    if (open_ready !== 1'b1) $display("FAIL full_resolve_open_ready: got %b want 1", open_ready); else n_pass++;
    tick(); idle();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, 2'b11, '0, 2, 0))
      $display("FAIL open_and_resolve: got %h want %h", obs, pack(0, 0, 31'h77, 2'b11, '0, 2, 0));
    else n_pass++;
  endtask

  task automatic test_squash();
    res_valid = 1; res_ok = 0; a_valid = 1; a_push = 1; a_data = 31'h99; open_valid = 1;
    #1;
    n_checks++;
    if (rdy !== 3'b000) $display("FAIL squash_ready: got %b want 000", rdy); else n_pass++;
    tick(); idle();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, '0, 2'b11, 0, 0))
      $display("FAIL squash_out: got %h want %h", obs, pack(0, 0, 31'h77, '0, 2'b11, 0, 0));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, '0, '0, 0, 0))
      $display("FAIL squash_pulse: got %h want %h", obs, pack(0, 0, 31'h77, '0, '0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_err();
    res_valid = 1; res_ok = 1;
    tick(); idle();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, '0, '0, 0, 1))
      $display("FAIL err_set: got %h want %h", obs, pack(0, 0, 31'h77, '0, '0, 0, 1));
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    open_valid = 1;
    tick(); tick(); idle();
    n_checks++;
    if (obs !== pack(0, 0, 31'h77, 2'b01, '0, 2, 1))
      $display("FAIL pre_reset: got %h want %h", obs, pack(0, 0, 31'h77, 2'b01, '0, 2, 1));
    else n_pass++;
    rst_i = 1; res_valid = 1; res_ok = 0;
    #1;
    n_checks++;
    if (rdy !== 3'b000) $display("FAIL mid_reset_ready: got %b want 000", rdy); else n_pass++;
    tick();
    n_checks++;
    if (obs !== '0) $display("FAIL mid_reset_out: got %h want 0", obs); else n_pass++;
    rst_i = 0; idle();
    tick();
    n_checks++;
    if (obs !== '0) $display("FAIL post_reset_out: got %h want 0", obs); else n_pass++;
  endtask

  task automatic test_random();
    int               win[$];
    int               next_id;
    int               sz;
    logic             sq, e_a, e_b, e_o, ep, eq, merr;
    logic [WIDTH-1:0] mdin;
    logic [STAGES-1:0] ec, ef;
    idle(); rst_i = 1;
    tick();
    rst_i = 0;
    next_id = 0; merr = 0; mdin = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_push = 1'($urandom_range(0, 1)); a_pop = 1'($urandom_range(0, 1));
      a_data = WIDTH'($urandom);
      b_valid = ($urandom_range(0, 3) == 0);
      b_push = 1'($urandom_range(0, 1)); b_pop = 1'($urandom_range(0, 1));
      b_data = WIDTH'($urandom);
      open_valid = 1'($urandom_range(0, 1));
      res_valid = ($urandom_range(0, 2) == 0);
      res_ok = ($urandom_range(0, 3) != 0);
      sz = win.size();
      sq = res_valid && !res_ok && (sz > 0);
      e_b = !sq;
      e_a = !sq && !b_valid;
      e_o = !sq && ((sz < STAGES) || (res_valid && res_ok));
      #1;
      n_checks++;
      if (rdy !== {e_a, e_b, e_o})
        $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, rdy, {e_a, e_b, e_o});
      else n_pass++;
      ep = 0; eq = 0; ec = '0; ef = '0;
      if (sq) begin
        for (int i = 0; i < sz; i++) ef[i] = 1'b1;
        win.delete();
      end else begin
        if (b_valid) begin
          ep = b_push; eq = b_pop; mdin = b_data;
        end else if (a_valid) begin
          ep = a_push; eq = a_pop; mdin = a_data;
        end
        if (res_valid && res_ok && sz > 0) begin
          ec[STAGES-1] = 1'b1;
          void'(win.pop_front());
        end
        if (open_valid && e_o) begin
          ec[0] = 1'b1;
          win.push_back(next_id);
          next_id++;
        end
      end
      if (res_valid && sz == 0) merr = 1'b1;
      tick();
      n_checks++;
      if (obs !== pack(ep, eq, mdin, ec, ef, win.size(), merr))
        $display("FAIL rand_out cyc %0d: got %h want %h", cyc, obs, pack(ep, eq, mdin, ec, ef, win.size(), merr));
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    rst_i = 1;
    idle();
    test_reset();
    test_push_a();
    test_priority();
    test_open_full();
    test_squash();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
